// File: rtl/icache_ram_pkg.sv
// Shared types for the multi-way L1.5 icache data RAM.
// Widths here follow the default array configuration.
package icache_ram_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_ADDR_WIDTH = 7;
   localparam int DEF_NB_WAYS    = 4;

   typedef logic [$clog2(DEF_NB_WAYS)-1:0]        way_idx_t;
   typedef logic [DEF_DATA_WIDTH-1:0]             way_word_t;
   typedef logic [DEF_NB_WAYS*DEF_DATA_WIDTH-1:0] all_ways_t;

   typedef enum logic {INIT, RUN} ram_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_data_ram_bank.sv
// One cache way: byte-enabled synchronous single-port RAM.
// Read data only moves on a read, so a held result survives idle and write cycles.
module icache_data_ram_bank
   import icache_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7,
   parameter int BE_WIDTH   = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [BE_WIDTH-1:0]   be,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (req && we) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)             rdata <= '0;
      else if (req && !we) rdata <= mem[addr];
   end

endmodule

// File: rtl/icache_data_ram_mway.sv
// Multi-way icache data RAM: parallel way read, per-way byte-enabled write,
// reset-time zero sweep and a backpressured read-valid pipeline.
module icache_data_ram_mway
   import icache_ram_pkg::*;
#(
   parameter int  DATA_WIDTH = 64,
   parameter int  ADDR_WIDTH = 7,
   parameter int  NB_WAYS    = 4,
   parameter int  BE_WIDTH   = DATA_WIDTH/8,
   parameter int  OUT_REG    = 1,
   parameter int  INIT_ZERO  = 1,
   localparam int WAY_W      = idx_width(NB_WAYS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_i,
   output logic                          gnt_o,
   input  logic                          we_i,
   input  logic [WAY_W-1:0]              way_i,
   input  logic [ADDR_WIDTH-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0]         wdata_i,
   input  logic [BE_WIDTH-1:0]           be_i,
   output logic                          rvalid_o,
   input  logic                          rready_i,
   output logic [NB_WAYS*DATA_WIDTH-1:0] rdata_o,
   output logic                          init_done_o
);

   ram_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_d;
   logic                  in_init, acc, rd_acc;
   logic                  s1_valid_q, load, hold, out_valid;
   logic [NB_WAYS*DATA_WIDTH-1:0] bank_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= (INIT_ZERO != 0) ? INIT : RUN;
         cnt_q       <= '0;
         init_done_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_o <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = init_done_o;
      unique case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = RUN;
               done_d  = 1'b1;
            end
         end
         RUN:     done_d = 1'b1;
         default: ;
      endcase
   end

   assign in_init = (state_q == INIT);
   assign gnt_o   = (state_q == RUN) && init_done_o && !rst && !hold;
   assign acc     = req_i && gnt_o;
   assign rd_acc  = acc && !we_i;

   for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
      logic sel;
      assign sel = in_init || (acc && (!we_i || way_i == WAY_W'(w)));
      icache_data_ram_bank #(
         .DATA_WIDTH(DATA_WIDTH),
         .ADDR_WIDTH(ADDR_WIDTH),
         .BE_WIDTH  (BE_WIDTH)
      ) u_bank (
         .clk  (clk),
         .rst  (rst),
         .req  (sel),
         .we   (in_init || we_i),
         .addr (in_init ? cnt_q : addr_i),
         .wdata(in_init ? '0 : wdata_i),
         .be   (in_init ? '1 : be_i),
         .rdata(bank_rdata[w*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // s1 holds the bank output; with OUT_REG it drains into a skid-free output register
   if (OUT_REG != 0) begin : g_oreg
      logic                          vq;
      logic [NB_WAYS*DATA_WIDTH-1:0] dq;
      assign load = s1_valid_q && (!vq || rready_i);
      always_ff @(posedge clk) begin
         if (rst) begin
            vq <= 1'b0;
            dq <= '0;
         end else begin
            if (load) dq <= bank_rdata;
            vq <= load || (vq && !rready_i);
         end
      end
      assign out_valid = vq;
      assign rdata_o   = dq;
      assign hold      = s1_valid_q && vq && !rready_i;
   end else begin : g_noreg
      assign load      = rready_i;
      assign out_valid = s1_valid_q;
      assign rdata_o   = bank_rdata;
      assign hold      = s1_valid_q && !rready_i;
   end

   always_ff @(posedge clk) begin
      if (rst) s1_valid_q <= 1'b0;
      else     s1_valid_q <= rd_acc || (s1_valid_q && !load);
   end

   assign rvalid_o = out_valid && !rst;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && acc && we_i)
         assert ({1'b0, way_i} < (WAY_W+1)'(NB_WAYS))
         else $error("icache_data_ram_mway: write to way %0d dropped", way_i);
   end
`endif

endmodule

// File: tb/tb_icache_data_ram_mway.sv
// Randomized bench for icache_data_ram_mway against a per-way array model
// with an in-order queue of expected read lines.
module tb_icache_data_ram_mway;

   localparam int DW = 64;
   localparam int AW = 7;
   localparam int NW = 4;
   localparam int BW = DW/8;
   localparam int OR = 1;
   localparam int IZ = 1;
   localparam int WW = 2;
   localparam int DEPTH = 2**AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req = 1'b0;
   logic we = 1'b0;
   logic rready = 1'b1;
   logic gnt, rvalid, init_done;
   logic [WW-1:0] way = '0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [BW-1:0] be = '0;
   logic [NW*DW-1:0] rdata;

   int total = 0;
   int bad = 0;

   logic [DW-1:0]    model [NW][DEPTH];
   logic [NW*DW-1:0] exp_q [$];

   logic s_gnt, s_acc, s_rv, s_take;
   logic [NW*DW-1:0] s_rd, s_exp;

   always #5 clk = ~clk;

   icache_data_ram_mway #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_WAYS(NW),
      .BE_WIDTH(BW), .OUT_REG(OR), .INIT_ZERO(IZ)
   ) dut (
      .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
      .way_i(way), .addr_i(addr), .wdata_i(wdata), .be_i(be),
      .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
      .init_done_o(init_done)
   );

   function automatic logic [NW*DW-1:0] ref_line(input logic [AW-1:0] a);
      logic [NW*DW-1:0] v;
      for (int w = 0; w < NW; w++) v[w*DW +: DW] = model[w][a];
      return v;
   endfunction

   task automatic clear_model();
      for (int w = 0; w < NW; w++)
         for (int a = 0; a < DEPTH; a++) model[w][a] = '0;
      exp_q.delete();
   endtask

   // One clock: sample handshakes mid-cycle, advance the model, then cross the edge.
   task automatic tick();
      @(negedge clk);
      s_gnt  = gnt;
      s_acc  = req && gnt;
      s_rv   = rvalid;
      s_rd   = rdata;
      s_take = rvalid && rready;
      if (s_take) s_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      if (s_acc && we) begin
         for (int b = 0; b < BW; b++)
            if (be[b]) model[way][addr][b*8 +: 8] = wdata[b*8 +: 8];
      end else if (s_acc) begin
         exp_q.push_back(ref_line(addr));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int w, input int a, input logic [DW-1:0] d,
                     input logic [BW-1:0] b);
      int n = 0;
      req = 1; we = 1; way = WW'(w); addr = AW'(a); wdata = d; be = b;
      do begin tick(); n++; end while (!s_acc && n < 20);
      if (!s_acc) begin
         total++; bad++;
         $display("FAIL wr_timeout addr=%0d", a);
      end
      req = 0; we = 0;
   endtask

   task automatic rd(input int a, output int n);
      n = 0;
      req = 1; we = 0; addr = AW'(a);
      do begin tick(); n++; end while (!s_acc && n < 20);
      if (!s_acc) begin
         total++; bad++;
         $display("FAIL rd_timeout addr=%0d", a);
      end
      req = 0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      do begin tick(); lat++; end while (!s_take && lat < 20);
   endtask

   task automatic count_init(input string tag);
      int n = 0;
      bit gbad = 0;
      while (!init_done && n < 400) begin
         if (gnt || rvalid) gbad = 1;
         tick();
         n++;
      end
      total++;
      if (n !== DEPTH) begin
         bad++;
         $display("FAIL %s_init_cycles got=%0d want=%0d", tag, n, DEPTH);
      end
      total++;
      if (gbad) begin
         bad++;
         $display("FAIL %s_gnt_during_init got=1 want=0", tag);
      end
   endtask

   task automatic test_reset();
      int lat, n;
      rst = 1; req = 0; rready = 1;
      tick(); tick();
      rst = 0;
      #1;
      total++;
      if (gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", gnt); end
      total++;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
      total++;
      if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
      total++;
      if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b want=0", init_done); end
      clear_model();
      count_init("reset");
      rd($urandom_range(0, DEPTH-1), n);
      wait_resp(lat);
      total++;
      if (!s_take || s_rd !== '0) begin
         bad++;
         $display("FAIL init_zero_read got=%h want=0", s_rd);
      end
   endtask

   task automatic test_byte_enable();
      int lat, n;
      wr(2, 5, 64'h1122334455667788, 8'h0F);
      rd(5, n);
      wait_resp(lat);
      total++;
      if (s_rd[2*DW +: DW] !== 64'h0000000055667788) begin
         bad++;
         $display("FAIL be_way2 got=%h want=%h", s_rd[2*DW +: DW], 64'h55667788);
      end
      total++;
      if ({s_rd[3*DW +: DW], s_rd[DW +: DW], s_rd[0 +: DW]} !== '0) begin
         bad++;
         $display("FAIL be_other_ways got=%h want=0", s_rd);
      end
      total++;
      if (s_rd !== s_exp) begin
         bad++;
         $display("FAIL be_model got=%h want=%h", s_rd, s_exp);
      end
   endtask

   task automatic test_write_then_read();
      int lat, n;
      wr(0, 9, 64'hDEAD, 8'hFF);
      rd(9, n);
      total++;
      if (n !== 1) begin bad++; $display("FAIL wtr_b2b got=%0d want=1", n); end
      wait_resp(lat);
      total++;
      if (lat !== 1 + OR) begin
         bad++;
         $display("FAIL wtr_latency got=%0d want=%0d", lat, 1 + OR);
      end
      total++;
      if (s_rd[0 +: DW] !== 64'hDEAD) begin
         bad++;
         $display("FAIL wtr_data got=%h want=%h", s_rd[0 +: DW], 64'hDEAD);
      end
   endtask

   task automatic test_backpressure();
      int a [3];
      int n_acc = 0;
      int takes = 0;
      int n = 0;
      logic [NW*DW-1:0] h;
      bit held_ok = 1;
      for (int i = 0; i < 3; i++) begin
         a[i] = 20 + i;
         wr($urandom_range(0, NW-1), a[i], {$urandom, $urandom}, 8'hFF);
      end
      rready = 0;
      req = 1; we = 0; addr = AW'(a[0]);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (s_acc) begin
            n_acc++;
            addr = AW'(a[n_acc]);
         end
      end
      total++;
      if (n_acc !== 1 + OR) begin
         bad++;
         $display("FAIL bp_accepted got=%0d want=%0d", n_acc, 1 + OR);
      end
      total++;
      if (s_gnt !== 1'b0) begin bad++; $display("FAIL bp_gnt got=%b want=0", s_gnt); end
      h = rdata;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (s_rv !== 1'b1 || s_rd !== h) held_ok = 0;
      end
      total++;
      if (!held_ok) begin bad++; $display("FAIL bp_hold got=%h want=%h", s_rd, h); end
      rready = 1;
      while (takes < 3 && n < 30) begin
         tick();
         n++;
         if (s_acc) begin
            n_acc++;
            if (n_acc >= 3) req = 0;
            else addr = AW'(a[n_acc]);
         end
         if (s_take) begin
            takes++;
            total++;
            if (s_rd !== s_exp) begin
               bad++;
               $display("FAIL bp_drain got=%h want=%h", s_rd, s_exp);
            end
         end
      end
      req = 0;
      total++;
      if (takes !== 3) begin bad++; $display("FAIL bp_drain_count got=%0d want=3", takes); end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      int takes = 0;
      int first_acc = -1, last_acc = -1, first_t = -1, last_t = -1;
      for (int i = 0; i < 16; i++)
         wr($urandom_range(0, NW-1), 40 + i, {$urandom, $urandom}, BW'($urandom));
      rready = 1;
      req = 1; we = 0; addr = AW'(40);
      for (int i = 0; i < 24; i++) begin
         tick();
         if (s_acc) begin
            if (first_acc < 0) first_acc = i;
            last_acc = i;
            k++;
            if (k == 16) req = 0;
            else addr = AW'(40 + k);
         end
         if (s_take) begin
            if (first_t < 0) first_t = i;
            last_t = i;
            takes++;
            total++;
            if (s_rd !== s_exp) begin
               bad++;
               $display("FAIL b2b_data got=%h want=%h", s_rd, s_exp);
            end
         end
      end
      req = 0;
      total++;
      if (last_acc - first_acc !== 15 || k !== 16) begin
         bad++;
         $display("FAIL b2b_accept_span got=%0d want=15", last_acc - first_acc);
      end
      total++;
      if (takes !== 16 || last_t - first_t !== 15) begin
         bad++;
         $display("FAIL b2b_rvalid_run got=%0d want=16", takes);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      int n = 0;
      for (int i = 0; i < 400; i++) begin
         req = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 9) < 4);
         way = WW'($urandom_range(0, NW-1));
         addr = AW'($urandom_range(0, 15));
         wdata = {$urandom, $urandom};
         be = BW'($urandom);
         rready = ($urandom_range(0, 9) < 7);
         tick();
         if (s_take) begin
            total++;
            if (s_rd !== s_exp) begin
               bad++;
               errs++;
               if (errs < 5) $display("FAIL rand_data got=%h want=%h", s_rd, s_exp);
            end
         end
      end
      req = 0; rready = 1;
      while ((exp_q.size() > 0 || rvalid) && n < 20) begin
         tick();
         n++;
         if (s_take) begin
            total++;
            if (s_rd !== s_exp) begin
               bad++;
               $display("FAIL rand_drain got=%h want=%h", s_rd, s_exp);
            end
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rand_lost got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_read();
      int n, lat;
      bit seen = 0;
      wr(1, 30, 64'hCAFEF00D12345678, 8'hFF);
      rd(30, n);
      rst = 1;
      exp_q.delete();
      tick();
      if (s_rv) seen = 1;
      tick();
      if (s_rv) seen = 1;
      total++;
      if (init_done !== 1'b0) begin bad++; $display("FAIL mid_init_done got=%b want=0", init_done); end
      rst = 0;
      clear_model();
      count_init("mid");
      total++;
      if (seen) begin bad++; $display("FAIL mid_rvalid got=1 want=0"); end
      rd(30, n);
      wait_resp(lat);
      total++;
      if (!s_take || s_rd !== '0) begin
         bad++;
         $display("FAIL mid_reclear got=%h want=0", s_rd);
      end
   endtask

   initial begin
      test_reset();
      test_byte_enable();
      test_write_then_read();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
